acc_sequencer: RTL

ACC_SEQUENCER -- requirements
Module: acc_sequencer

---
 rtl/acc_seq_pkg.sv | 37 +++
 rtl/acc_seq_alu.sv | 30 +++
 rtl/acc_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/acc_seq_pkg.sv
// rtl/acc_seq_pkg.sv - opcodes, FSM states and field widths for acc_sequencer (ACC_SEQ_MUL_EN adds MUL as a memory-operand op)
package acc_seq_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_HALT  = 4'h0;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'h1;
  localparam logic [OP_W-1:0] OP_STORE = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OP_W-1:0] OP_AND   = 4'h5;
  localparam logic [OP_W-1:0] OP_OR    = 4'h6;
  localparam logic [OP_W-1:0] OP_JUMP  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ    = 4'h8;
  localparam logic [OP_W-1:0] OP_CLEAR = 4'h9;
  localparam logic [OP_W-1:0] OP_MUL   = 4'hA;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_EXEC,
    ST_HALT
  } state_t;

  // Opcodes that need an operand cycle on the memory bus
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR: is_mem_op = 1'b1;
`ifdef ACC_SEQ_MUL_EN
      OP_MUL:                                           is_mem_op = 1'b1;
`endif
      default:                                          is_mem_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/acc_seq_alu.sv
// rtl/acc_seq_alu.sv - combinational EXEC datapath; multiplier only exists when ACC_SEQ_MUL_EN is defined
import acc_seq_pkg::*;

module acc_seq_alu #(
  parameter int DATA_W = 16
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] mbr,
  output logic [DATA_W-1:0] result
);

  // New ACC value; opcodes that do not touch ACC pass it through unchanged
  always_comb begin
    result = acc;
    case (op)
      OP_LOAD:  result = mbr;
      OP_ADD:   result = acc + mbr;
      OP_SUB:   result = acc - mbr;
      OP_AND:   result = acc & mbr;
      OP_OR:    result = acc | mbr;
      OP_CLEAR: result = '0;
`ifdef ACC_SEQ_MUL_EN
      OP_MUL:   result = acc * mbr;
`endif
      default:  result = acc;
    endcase
  end

endmodule

// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - single-accumulator instruction sequencer with req/ack memory port; ACC_SEQ_MUL_EN enables opcode A as MUL
import acc_seq_pkg::*;

module acc_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   mbr;
  logic [DATA_W-1:0]   acc;
  logic [OP_W-1:0]     op;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   alu_res;
  logic [ADDR_W-1:0]   exec_pc;
  logic                unused_ir;

  assign op        = ir[DATA_W-1 -: OP_W];
  assign operand   = ir[ADDR_W-1:0];
  assign unused_ir = ^ir;
  assign acc_out   = acc;
  assign pc_out    = pc;

  acc_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .acc    (acc),
    .mbr    (mbr),
    .result (alu_res)
  );

  // PC after EXEC: branch target for JUMP and taken JZ, else the already-incremented PC
  always_comb begin
    exec_pc = pc;
    if (op == OP_JUMP || (op == OP_JZ && acc == '0))
      exec_pc = mar;
  end

  // Main FSM; bus outputs are registered and set on entry to FETCH/MEM so they hold until the ack
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ir        <= '0;
      mar       <= '0;
      mbr       <= '0;
      acc       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!mem_req) begin
            // only reached straight after reset: launch the first fetch
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc + 1'b1;
            mem_req <= 1'b0;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          mar <= operand;
          if (is_mem_op(op)) begin
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_STORE);
            mem_addr  <= operand;
            mem_wdata <= acc;
            state     <= ST_MEM;
          end else if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (!mem_we)
              mbr <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          acc      <= alu_res;
          pc       <= exec_pc;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= exec_pc;
          state    <= ST_FETCH;
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
